// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Purpose
//   Shares one downstream bus-interface-unit (BIU) cache port between two
//   requesters: requester 0 (I-cache) and requester 1 (D-cache). Only one
//   transaction is in flight at a time. When both requesters are valid in the
//   same idle cycle, the winner alternates (round robin). A WAIT timeout
//   completes a stuck transaction with an error response.
//
// Parameters
//   AW      address width
//   DW      line data width
//   TIMEOUT maximum WAIT cycles before an error completion (0 = never)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   m<g>_req_vld_i/rdy_o/rd_i   requester g request handshake (rd=1 read)
//   m<g>_req_addr_i/wdata_i     requester g request payload
//   m<g>_resp_vld_o/ack_i       requester g response handshake
//   m<g>_resp_rdata_o/err_o     requester g response payload
//   biu_req_*                   downstream request (vld/rdy/rd/addr/wdata)
//   biu_resp_*                  downstream response (vld/ack/rdata/err)
//   busy_o                      a transaction is in progress
//   owner_o                     current or most recently granted requester
//   timeout_o                   one-cycle pulse when a timeout completes
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 512,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req_vld_i,
    output logic          m0_req_rdy_o,
    input  logic          m0_req_rd_i,
    input  logic [AW-1:0] m0_req_addr_i,
    input  logic [DW-1:0] m0_req_wdata_i,
    output logic          m0_resp_vld_o,
    input  logic          m0_resp_ack_i,
    output logic [DW-1:0] m0_resp_rdata_o,
    output logic          m0_resp_err_o,

    input  logic          m1_req_vld_i,
    output logic          m1_req_rdy_o,
    input  logic          m1_req_rd_i,
    input  logic [AW-1:0] m1_req_addr_i,
    input  logic [DW-1:0] m1_req_wdata_i,
    output logic          m1_resp_vld_o,
    input  logic          m1_resp_ack_i,
    output logic [DW-1:0] m1_resp_rdata_o,
    output logic          m1_resp_err_o,

    output logic          biu_req_vld_o,
    input  logic          biu_req_rdy_i,
    output logic          biu_req_rd_o,
    output logic [AW-1:0] biu_req_addr_o,
    output logic [DW-1:0] biu_req_wdata_o,
    input  logic          biu_resp_vld_i,
    output logic          biu_resp_ack_o,
    input  logic [DW-1:0] biu_resp_rdata_i,
    input  logic          biu_resp_err_i,

    output logic          busy_o,
    output logic          owner_o,
    output logic          timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // The counter compares against TIMEOUT-1; guard the subtraction so a
    // disabled timeout never underflows into a huge limit.
    localparam bit          TO_EN   = (TIMEOUT != 32'd0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 32'd1) : 16'd0;

    state_e        state_q;
    logic          owner_q;
    logic          last_grant_q;
    logic          rd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          timeout_q;
    logic [15:0]   cnt_q;

    logic          grant_vld_s;
    logic          grant_s;
    logic          accept_s;
    logic          owner_ack_s;
    logic          timeout_hit_s;
    logic          resp_phase_s;

    // Grant selection: a lone valid requester wins; on a tie the requester
    // that did not win last time is chosen.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        if (m0_req_vld_i && m1_req_vld_i) begin
            grant_vld_s = 1'b1;
            grant_s     = ~last_grant_q;
        end else if (m0_req_vld_i) begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b0;
        end else if (m1_req_vld_i) begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    assign accept_s      = (state_q == ST_IDLE) && grant_vld_s;
    assign owner_ack_s   = owner_q ? m1_resp_ack_i : m0_resp_ack_i;
    assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);
    assign resp_phase_s  = (state_q == ST_RESP);

    // Transaction FSM with its latched request, captured response, timeout
    // counter and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= 16'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_q <= grant_s;
                        rd_q    <= grant_s ? m1_req_rd_i    : m0_req_rd_i;
                        addr_q  <= grant_s ? m1_req_addr_i  : m0_req_addr_i;
                        wdata_q <= grant_s ? m1_req_wdata_i : m0_req_wdata_i;
                        cnt_q   <= 16'd0;
                        state_q <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (biu_req_rdy_i) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // A response in the timeout cycle takes priority.
                    if (biu_resp_vld_i) begin
                        rdata_q <= biu_resp_rdata_i;
                        err_q   <= biu_resp_err_i;
                        state_q <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (owner_ack_s) begin
                        last_grant_q <= owner_q;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Request side: ready only while idle and only towards the granted requester.
    assign m0_req_rdy_o = accept_s && !grant_s;
    assign m1_req_rdy_o = accept_s &&  grant_s;

    // Response side: only the owner sees the captured response; the other
    // requester's response payload is held at zero.
    assign m0_resp_vld_o   = resp_phase_s && !owner_q;
    assign m1_resp_vld_o   = resp_phase_s &&  owner_q;
    assign m0_resp_rdata_o = m0_resp_vld_o ? rdata_q : '0;
    assign m1_resp_rdata_o = m1_resp_vld_o ? rdata_q : '0;
    assign m0_resp_err_o   = m0_resp_vld_o && err_q;
    assign m1_resp_err_o   = m1_resp_vld_o && err_q;

    // Downstream request is driven straight from the latched copy so it is
    // stable for as long as the BIU stalls.
    assign biu_req_vld_o   = (state_q == ST_REQ);
    assign biu_req_rd_o    = rd_q;
    assign biu_req_addr_o  = addr_q;
    assign biu_req_wdata_o = wdata_q;

    // Every BIU response is consumed; ones arriving outside WAIT are dropped.
    assign biu_resp_ack_o  = biu_resp_vld_i;

    assign busy_o    = (state_q != ST_IDLE);
    assign owner_o   = owner_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    localparam int AW      = 64;
    localparam int DW      = 512;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          m0_req_vld_i, m0_req_rdy_o, m0_req_rd_i;
    logic [AW-1:0] m0_req_addr_i;
    logic [DW-1:0] m0_req_wdata_i;
    logic          m0_resp_vld_o, m0_resp_ack_i, m0_resp_err_o;
    logic [DW-1:0] m0_resp_rdata_o;

    logic          m1_req_vld_i, m1_req_rdy_o, m1_req_rd_i;
    logic [AW-1:0] m1_req_addr_i;
    logic [DW-1:0] m1_req_wdata_i;
    logic          m1_resp_vld_o, m1_resp_ack_i, m1_resp_err_o;
    logic [DW-1:0] m1_resp_rdata_o;

    logic          biu_req_vld_o, biu_req_rdy_i, biu_req_rd_o;
    logic [AW-1:0] biu_req_addr_o;
    logic [DW-1:0] biu_req_wdata_o;
    logic          biu_resp_vld_i, biu_resp_ack_o, biu_resp_err_i;
    logic [DW-1:0] biu_resp_rdata_i;

    logic          busy_o, owner_o, timeout_o;

    always #5 clk = ~clk;

    mem_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_req_vld_i     (m0_req_vld_i),
        .m0_req_rdy_o     (m0_req_rdy_o),
        .m0_req_rd_i      (m0_req_rd_i),
        .m0_req_addr_i    (m0_req_addr_i),
        .m0_req_wdata_i   (m0_req_wdata_i),
        .m0_resp_vld_o    (m0_resp_vld_o),
        .m0_resp_ack_i    (m0_resp_ack_i),
        .m0_resp_rdata_o  (m0_resp_rdata_o),
        .m0_resp_err_o    (m0_resp_err_o),
        .m1_req_vld_i     (m1_req_vld_i),
        .m1_req_rdy_o     (m1_req_rdy_o),
        .m1_req_rd_i      (m1_req_rd_i),
        .m1_req_addr_i    (m1_req_addr_i),
        .m1_req_wdata_i   (m1_req_wdata_i),
        .m1_resp_vld_o    (m1_resp_vld_o),
        .m1_resp_ack_i    (m1_resp_ack_i),
        .m1_resp_rdata_o  (m1_resp_rdata_o),
        .m1_resp_err_o    (m1_resp_err_o),
        .biu_req_vld_o    (biu_req_vld_o),
        .biu_req_rdy_i    (biu_req_rdy_i),
        .biu_req_rd_o     (biu_req_rd_o),
        .biu_req_addr_o   (biu_req_addr_o),
        .biu_req_wdata_o  (biu_req_wdata_o),
        .biu_resp_vld_i   (biu_resp_vld_i),
        .biu_resp_ack_o   (biu_resp_ack_o),
        .biu_resp_rdata_i (biu_resp_rdata_i),
        .biu_resp_err_i   (biu_resp_err_i),
        .busy_o           (busy_o),
        .owner_o          (owner_o),
        .timeout_o        (timeout_o)
    );

    int check_cnt = 0;
    int error_cnt = 0;

    // Reference state: who won the last completed transaction (reset -> 1,
    // so requester 0 wins the first tie).
    bit model_last;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        check_cnt = check_cnt + 1;
        if (got !== exp) begin
            error_cnt = error_cnt + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic get_rdy(input logic g);
        return g ? m1_req_rdy_o : m0_req_rdy_o;
    endfunction

    function automatic logic get_rvld(input logic g);
        return g ? m1_resp_vld_o : m0_resp_vld_o;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input logic g);
        return g ? m1_resp_rdata_o : m0_resp_rdata_o;
    endfunction

    function automatic logic get_rerr(input logic g);
        return g ? m1_resp_err_o : m0_resp_err_o;
    endfunction

    // Sample point is the falling edge; inputs also change there.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},     busy_o, 1'b0);
        check_eq({tag, "_owner"},    owner_o, 1'b0);
        check_eq({tag, "_timeout"},  timeout_o, 1'b0);
        check_eq({tag, "_biu_vld"},  biu_req_vld_o, 1'b0);
        check_eq({tag, "_rdy"},      {m1_req_rdy_o, m0_req_rdy_o}, 2'b00);
        check_eq({tag, "_resp_vld"}, {m1_resp_vld_o, m0_resp_vld_o}, 2'b00);
        check_eq({tag, "_rdata0"},   m0_resp_rdata_o, '0);
        check_eq({tag, "_rdata1"},   m1_resp_rdata_o, '0);
        check_eq({tag, "_err"},      {m1_resp_err_o, m0_resp_err_o}, 2'b00);
    endtask

    // One complete transaction, entered and left at an idle falling edge.
    // resp_dly < 0 means the BIU never answers.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input int rdy_dly, input int resp_dly,
                           input logic [DW-1:0] bdata, input logic berr,
                           input int ack_dly, input bit stray);
        bit            win;
        bit            tie;
        bit            got_resp;
        int            n_wait;
        logic          r0, r1, w_rd;
        logic [DW-1:0] d0, d1, w_wd, exp_data;
        logic [AW-1:0] w_addr;
        logic          exp_err;

        r0  = 1'($urandom_range(0, 1));
        r1  = 1'($urandom_range(0, 1));
        d0  = rand_wide();
        d1  = rand_wide();
        tie = v0 && v1;
        win = tie ? ~model_last : v1;
        w_rd   = win ? r1 : r0;
        w_addr = win ? a1 : a0;
        w_wd   = win ? d1 : d0;

        m0_req_vld_i = v0; m0_req_rd_i = r0; m0_req_addr_i = a0; m0_req_wdata_i = d0;
        m1_req_vld_i = v1; m1_req_rd_i = r1; m1_req_addr_i = a1; m1_req_wdata_i = d1;
        #1;
        check_eq("rdy_winner", get_rdy(win), 1'b1);
        check_eq("rdy_other", get_rdy(~win), 1'b0);
        check_eq("busy_idle", busy_o, 1'b0);
        next_cycle();

        if (win) m1_req_vld_i = 1'b0;
        else     m0_req_vld_i = 1'b0;

        // Request phase: biu request visible one cycle after acceptance.
        for (int k = 0; k <= rdy_dly; k++) begin
            #1;
            check_eq("biu_vld", biu_req_vld_o, 1'b1);
            check_eq("biu_addr", biu_req_addr_o, w_addr);
            check_eq("biu_rd", biu_req_rd_o, w_rd);
            check_eq("biu_wdata", biu_req_wdata_o, w_wd);
            check_eq("owner_req", owner_o, win);
            check_eq("busy_req", busy_o, 1'b1);
            check_eq("rdy_busy", {m1_req_rdy_o, m0_req_rdy_o}, 2'b00);
            biu_req_rdy_i = (k == rdy_dly);
            next_cycle();
        end
        biu_req_rdy_i = 1'b0;

        // Wait phase: answer arrives at wait index resp_dly unless the
        // TIMEOUT-cycle budget expires first.
        got_resp = (resp_dly >= 0) && (resp_dly < TIMEOUT);
        n_wait   = got_resp ? resp_dly + 1 : TIMEOUT;
        exp_data = got_resp ? bdata : '0;
        exp_err  = got_resp ? berr : 1'b1;
        for (int i = 0; i < n_wait; i++) begin
            #1;
            check_eq("biu_vld_wait", biu_req_vld_o, 1'b0);
            check_eq("resp_early", {m1_resp_vld_o, m0_resp_vld_o}, 2'b00);
            check_eq("timeout_early", timeout_o, 1'b0);
            if (got_resp && i == resp_dly) begin
                biu_resp_vld_i = 1'b1; biu_resp_rdata_i = bdata; biu_resp_err_i = berr;
                #1;
                check_eq("biu_ack", biu_resp_ack_o, 1'b1);
            end
            next_cycle();
            biu_resp_vld_i   = 1'b0;
            biu_resp_rdata_i = rand_wide();
            biu_resp_err_i   = 1'($urandom_range(0, 1));
        end

        // Response phase: held stable until the owner acknowledges.
        for (int j = 0; j <= ack_dly; j++) begin
            #1;
            check_eq("resp_vld", get_rvld(win), 1'b1);
            check_eq("resp_rdata", get_rdata(win), exp_data);
            check_eq("resp_err", get_rerr(win), exp_err);
            check_eq("resp_other", get_rvld(~win), 1'b0);
            check_eq("rdy_resp", {m1_req_rdy_o, m0_req_rdy_o}, 2'b00);
            check_eq("timeout_pulse", timeout_o, (!got_resp) && (j == 0));
            if (stray && j == 0) begin
                biu_resp_vld_i = 1'b1;
                #1;
                check_eq("stray_ack_resp", biu_resp_ack_o, 1'b1);
            end
            if (win) m1_resp_ack_i = (j == ack_dly);
            else     m0_resp_ack_i = (j == ack_dly);
            next_cycle();
            biu_resp_vld_i = 1'b0;
            m0_resp_ack_i  = 1'b0;
            m1_resp_ack_i  = 1'b0;
        end
        model_last = win;

        #1;
        check_eq("busy_done", busy_o, 1'b0);
        check_eq("resp_done", {m1_resp_vld_o, m0_resp_vld_o}, 2'b00);
        check_eq("owner_last", owner_o, win);
        check_eq("timeout_done", timeout_o, 1'b0);
        if (tie) check_eq("rdy_loser_idle", get_rdy(~win), 1'b1);

        // Withdraw any pending request before it is accepted.
        m0_req_vld_i = 1'b0;
        m1_req_vld_i = 1'b0;
        if (stray) biu_resp_vld_i = 1'b1;
        #1;
        if (stray) check_eq("stray_ack_idle", biu_resp_ack_o, 1'b1);
        next_cycle();
        biu_resp_vld_i = 1'b0;
        #1;
        check_eq("idle_hold", busy_o, 1'b0);
        check_eq("idle_resp", {m1_resp_vld_o, m0_resp_vld_o}, 2'b00);
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        m0_req_vld_i = 1'b0; m0_req_rd_i = 1'b0; m0_req_addr_i = '0; m0_req_wdata_i = '0; m0_resp_ack_i = 1'b0;
        m1_req_vld_i = 1'b0; m1_req_rd_i = 1'b0; m1_req_addr_i = '0; m1_req_wdata_i = '0; m1_resp_ack_i = 1'b0;
        biu_req_rdy_i = 1'b0; biu_resp_vld_i = 1'b0; biu_resp_rdata_i = '0; biu_resp_err_i = 1'b0;
        model_last = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Tie out of reset: m0 first, then m1 (still pending) next.
        run_txn(1'b1, 1'b1, 64'h1000, 64'h2000, 0, 2, rand_wide(), 1'b0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 64'h1000, 64'h2000, 1, 0, rand_wide(), 1'b0, 0, 1'b0);
        // Tie again: m1 won last, so m0 wins.
        run_txn(1'b1, 1'b1, 64'h1000, 64'h2000, 0, 1, rand_wide(), 1'b1, 0, 1'b0);
        // m1 with delayed BIU ready and the A5 data pattern.
        run_txn(1'b0, 1'b1, 64'h40, 64'h80, 3, 2, {64{8'hA5}}, 1'b0, 0, 1'b0);
        // No BIU response: timeout, then stray responses are dropped.
        run_txn(1'b1, 1'b0, 64'h100, 64'h200, 0, -1, rand_wide(), 1'b0, 1, 1'b1);
        // Response in the last allowed cycle beats the timeout.
        run_txn(1'b0, 1'b1, 64'h300, 64'h400, 0, TIMEOUT - 1, rand_wide(), 1'b0, 0, 1'b0);
        // Owner holds off ack for 5 cycles while the other requester waits.
        run_txn(1'b1, 1'b1, 64'h500, 64'h600, 1, 3, rand_wide(), 1'b1, 5, 1'b0);

        // Reset while in WAIT.
        m0_req_vld_i = 1'b1; m0_req_addr_i = 64'h3000; m0_req_rd_i = 1'b1;
        next_cycle();
        m0_req_vld_i = 1'b0; biu_req_rdy_i = 1'b1;
        next_cycle();
        biu_req_rdy_i = 1'b0;
        #1;
        check_eq("busy_before_rst", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        next_cycle();
        rst_n = 1'b1;
        model_last = 1'b1;
        biu_resp_vld_i = 1'b1; biu_resp_rdata_i = rand_wide();
        #1;
        check_eq("late_ack", biu_resp_ack_o, 1'b1);
        next_cycle();
        biu_resp_vld_i = 1'b0;
        #1;
        check_eq("late_fwd", {m1_resp_vld_o, m0_resp_vld_o}, 2'b00);
        check_eq("late_busy", busy_o, 1'b0);
        run_txn(1'b1, 1'b1, 64'h7000, 64'h8000, 0, 0, rand_wide(), 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 10);
            run_txn(v[0], v[1], {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), (r == 10) ? -1 : r,
                    rand_wide(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter AW, 64, address width.
REQ-002 Parameter DW, 512, line data width.
REQ-003 Parameter TIMEOUT, 1024, max cycles in WAIT before error completion; 0 disables timeout; range 0..65535.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 m0_req_vld_i / m0_req_rdy_o / m0_req_rd_i  in/out/in  1 each  requester 0 (I-cache) request handshake; rd=1 read, 0 write.
REQ-007 m0_req_addr_i  in  AW, m0_req_wdata_i  in  DW  requester 0 request payload.
REQ-008 m0_resp_vld_o  out  1, m0_resp_ack_i  in  1, m0_resp_rdata_o  out  DW, m0_resp_err_o  out  1  requester 0 response.
REQ-009 m1_* ports identical to REQ-006..008 for requester 1 (D-cache).
REQ-010 biu_req_vld_o / biu_req_rdy_i / biu_req_rd_o  out/in/out  1 each, biu_req_addr_o  out  AW, biu_req_wdata_o  out  DW  downstream cache request port of the bus interface unit.
REQ-011 biu_resp_vld_i  in  1, biu_resp_ack_o  out  1, biu_resp_rdata_i  in  DW, biu_resp_err_i  in  1  downstream cache response.
REQ-012 busy_o  out  1  state != IDLE; owner_o  out  1  current/last granted requester; timeout_o  out  1  one-cycle pulse on timeout.

Function
REQ-013 FSM states: IDLE, REQ, WAIT, RESP; one transaction outstanding at a time.
REQ-014 IDLE: grant chosen combinationally; only one requester valid -> that one; both valid -> the one not equal to last_grant (round robin).
REQ-015 m<g>_req_rdy_o = 1 only in IDLE and only for granted requester g; other rdy = 0; both rdy = 0 outside IDLE.
REQ-016 On accept (vld&&rdy in IDLE): latch owner=g, rd, addr, wdata; next state REQ; timeout counter cleared.
REQ-017 REQ: biu_req_vld_o = 1 with latched rd/addr/wdata held stable; on biu_req_rdy_i -> WAIT; biu_req_vld_o = 0 in all other states.
REQ-018 Latency: accept at cycle T -> biu_req_vld_o high at T+1.
REQ-019 biu_resp_ack_o = biu_resp_vld_i in every state; responses arriving outside WAIT are acked and discarded.
REQ-020 WAIT: on biu_resp_vld_i capture rdata/err, -> RESP next cycle; requester sees resp_vld one cycle after biu_resp_vld_i.
REQ-021 WAIT timeout counter: 16-bit, increments each WAIT cycle without response; TIMEOUT!=0 and counter reaches TIMEOUT-1 without response -> RESP with rdata=0, err=1, timeout_o pulse.
REQ-022 Response and timeout in same cycle: response wins, no timeout_o.
REQ-023 RESP: m<owner>_resp_vld_o = 1 with captured rdata/err held stable until m<owner>_resp_ack_i; non-owner resp_vld_o = 0.
REQ-024 On owner ack: -> IDLE, last_grant <= owner; new request acceptable in following IDLE cycle (min 1 idle cycle between transactions).
REQ-025 Requester deasserting vld before acceptance: no grant, no state change.

Reset
REQ-026 rst_n low asynchronously forces IDLE, last_grant=1 (requester 0 wins first tie), counter=0, all vld/rdy/ack outputs 0, rdata outputs 0, err 0, busy_o 0, owner_o 0, timeout_o 0.
REQ-027 Reset mid-transaction drops it; no response delivered to either requester; late BIU response after reset is acked and discarded per REQ-019.

Verification
REQ-028 Both vld in same cycle out of reset, m0 addr 0x1000, m1 addr 0x2000 -> m0 granted first, biu_req_addr_o=0x1000; after m0 ack, m1 granted, addr 0x2000.
REQ-029 m1 read, biu_req_rdy_i delayed 3 cycles, BIU returns rdata pattern 0xA5.. err=0 -> m1_resp_vld_o one cycle after biu_resp_vld_i with same data; m0_resp_vld_o stays 0.
REQ-030 TIMEOUT=8, no BIU response -> after 8 WAIT cycles owner gets resp_vld, err=1, rdata=0, timeout_o one-cycle pulse; later stray biu_resp_vld_i acked, not forwarded.
REQ-031 Owner withholds resp_ack 5 cycles -> resp_vld/rdata stable all 5 cycles; other requester's rdy stays 0 until IDLE.
REQ-032 rst_n pulsed low in WAIT -> all outputs reset values immediately; next request after reset processed normally, m0 wins tie.
